shift_reg_sequencer: RTL and testbench
======================================

Name: shift_reg_sequencer

Overview:
- Command-driven controller that sequences a WIDTH-bit parallel/serial shift register.
- Accepts one command at a time over a valid/ready interface: parallel load, clear, N-bit serial shift, or a full load-then-shift-out transfer.
- Drives a serial output stream with a qualifying valid strobe.
- Reports completion with a one-cycle done pulse.
- Sits between a simple command master (test harness or FSM) and the serial link pins.

Parameters:
- WIDTH, 4, register width in bits; must be >= 2.
- CW, $clog2(WIDTH+1), width of the shift-count field.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high; clock clk.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command; high only in IDLE.
- cmd_op  input  2  00 LOAD, 01 SHIFT, 10 CLEAR, 11 XFER.
- cmd_data  input  WIDTH  parallel data for LOAD/XFER.
- cmd_count  input  CW  shift count for SHIFT.
- serial_in  input  1  bit shifted into the LSB on each shift cycle.
- serial_out  output  1  MSB shifted out, registered.
- serial_valid  output  1  serial_out holds a fresh bit this cycle.
- dout  output  WIDTH  current register contents, registered.
- busy  output  1  high while in SHIFT state.
- done  output  1  one-cycle pulse, command complete.

Behaviour:
- Reset (synchronous, priority over everything):
  - state=IDLE, register=0, cnt=0.
  - serial_out=0, serial_valid=0, done=0, busy=0.
  - cmd_ready=1 from the first cycle after reset.
- Accept rule: a command is accepted on a rising edge where cmd_valid && cmd_ready. cmd_op, cmd_data and cmd_count are sampled only on that edge.
- States: IDLE, SHIFT.
- In IDLE:
  - LOAD: register<=cmd_data on the accept edge; done=1 in the following cycle; stays IDLE. Back-to-back LOAD/CLEAR are accepted every cycle.
  - CLEAR: register<=0; otherwise identical to LOAD.
  - SHIFT with cmd_count==0: no-op; register unchanged, done=1 next cycle, stays IDLE.
  - SHIFT with cmd_count>=1: cnt<=min(cmd_count,WIDTH); values above WIDTH saturate to WIDTH. Go to SHIFT.
  - XFER: register<=cmd_data, cnt<=WIDTH, go to SHIFT.
- In SHIFT, every edge:
  - serial_out<=register[WIDTH-1], serial_valid<=1.
  - register<={register[WIDTH-2:0], serial_in}.
  - cnt<=cnt-1.
  - When cnt==1 on that edge: go to IDLE and done<=1. done therefore coincides with the last serial_valid cycle.
- Latency: SHIFT/XFER of N bits has cmd_ready low and busy high for exactly N cycles. serial_valid is high for N consecutive cycles, starting the cycle after the first SHIFT-state edge.
- serial_valid is 0 in every other cycle; serial_out holds its last value when invalid.
- cmd_valid is ignored while in SHIFT; the master must hold it until ready.
- dout is always the register contents; it updates on the same edge as the register.
- Reset mid-SHIFT: the in-flight command is aborted, no done pulse, register=0, IDLE next cycle.

Decomposition:
- Package shift_reg_seq_pkg:
  - op_t enum (OP_LOAD, OP_SHIFT, OP_CLEAR, OP_XFER).
  - state_t enum (S_IDLE, S_SHIFT).
- Sub-module shift_reg_core: the datapath only.
  - Inputs: clk, reset, load, clear, shift_en, par_in, ser_in.
  - Outputs: q, msb.
  - Priority: reset > clear > load > shift_en.
- The sequencer holds the FSM, counter and handshake, and drives shift_reg_core's control lines.

Test Plan:
- Reset held 2 cycles -> dout=0000, serial_valid=0, done=0, busy=0, cmd_ready=1.
- LOAD cmd_data=1010 -> dout=1010 the cycle after accept; done pulses one cycle; cmd_ready stays 1; back-to-back CLEAR next cycle -> dout=0000 with a second done.
- XFER cmd_data=1101, serial_in=0 -> serial_out=1,1,0,1 with serial_valid high 4 cycles; cmd_ready low 4 cycles; done on the 4th; final dout=0000.
- From dout=1010, SHIFT cmd_count=2, serial_in=1 -> serial_out=1,0; dout=0101 then 1011; done with the 2nd bit.
- SHIFT cmd_count=0 -> done next cycle, dout unchanged, no serial_valid. SHIFT cmd_count=7 (CW=3) -> saturates to 4 shifts.
- XFER 1111 with reset asserted on the 2nd shift cycle -> next cycle IDLE, dout=0000, serial_valid=0, no done pulse, cmd_ready=1.

Source files
------------

// File: rtl/shift_reg_sequencer_pkg.sv
// Shared types for the shift register sequencer: command opcodes and FSM states.
package shift_reg_seq_pkg;

   typedef enum logic [1:0] {
      OP_LOAD  = 2'b00,
      OP_SHIFT = 2'b01,
      OP_CLEAR = 2'b10,
      OP_XFER  = 2'b11
   } op_t;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/shift_reg_sequencer_if.sv
// Command valid/ready channel between a command master and the sequencer.
interface shift_reg_sequencer_if #(
   parameter int WIDTH = 4,
   parameter int CW    = $clog2(WIDTH + 1)
);
   import shift_reg_seq_pkg::*;

   logic             cmd_valid;
   logic             cmd_ready;
   op_t              cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic [CW-1:0]    cmd_count;

   modport master (output cmd_valid, output cmd_op, output cmd_data, output cmd_count,
                   input  cmd_ready);
   modport slave  (input  cmd_valid, input  cmd_op, input  cmd_data, input  cmd_count,
                   output cmd_ready);
endinterface

// File: rtl/shift_reg_sequencer_core.sv
// Parallel-load / serial-shift register datapath; shifts toward the MSB, filling the LSB.
module shift_reg_core #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             clear,
   input  logic             shift_en,
   input  logic [WIDTH-1:0] par_in,
   input  logic             ser_in,
   output logic [WIDTH-1:0] q,
   output logic             msb
);

   always_ff @(posedge clk) begin
      if (reset)         q <= '0;
      else if (clear)    q <= '0;
      else if (load)     q <= par_in;
      else if (shift_en) q <= {q[WIDTH-2:0], ser_in};
   end

   assign msb = q[WIDTH-1];

endmodule

// File: rtl/shift_reg_sequencer.sv
// Command sequencer: accepts LOAD/SHIFT/CLEAR/XFER, drives the shift register core
// and streams the MSB out with a valid strobe and a done pulse on completion.
module shift_reg_sequencer
   import shift_reg_seq_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   shift_reg_sequencer_if.slave  cmd,
   input  logic                  serial_in,
   output logic                  serial_out,
   output logic                  serial_valid,
   output logic [WIDTH-1:0]      dout,
   output logic                  busy,
   output logic                  done
);

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          done_n, valid_n;
   logic          load, clear, shift_en, msb;

   function automatic logic [CW-1:0] sat_count(input logic [CW-1:0] c);
      if (c > CW'(WIDTH)) return CW'(WIDTH);
      else                return c;
   endfunction

   shift_reg_core #(.WIDTH(WIDTH)) u_core (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .clear    (clear),
      .shift_en (shift_en),
      .par_in   (cmd.cmd_data),
      .ser_in   (serial_in),
      .q        (dout),
      .msb      (msb)
   );

   assign cmd.cmd_ready = (state == S_IDLE);
   assign busy          = (state == S_SHIFT);

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      load     = 1'b0;
      clear    = 1'b0;
      shift_en = 1'b0;
      done_n   = 1'b0;
      valid_n  = 1'b0;
      case (state)
         S_IDLE: begin
            if (cmd.cmd_valid) begin
               case (cmd.cmd_op)
                  OP_LOAD: begin
                     load   = 1'b1;
                     done_n = 1'b1;
                  end
                  OP_CLEAR: begin
                     clear  = 1'b1;
                     done_n = 1'b1;
                  end
                  OP_SHIFT: begin
                     if (cmd.cmd_count == '0) begin
                        done_n = 1'b1;
                     end else begin
                        cnt_n   = sat_count(cmd.cmd_count);
                        state_n = S_SHIFT;
                     end
                  end
                  OP_XFER: begin
                     load    = 1'b1;
                     cnt_n   = CW'(WIDTH);
                     state_n = S_SHIFT;
                  end
                  default: ;
               endcase
            end
         end
         S_SHIFT: begin
            shift_en = 1'b1;
            valid_n  = 1'b1;
            cnt_n    = cnt - CW'(1);
            // last bit leaves on this edge, so done lines up with its valid cycle
            if (cnt == CW'(1)) begin
               state_n = S_IDLE;
               done_n  = 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         cnt          <= '0;
         done         <= 1'b0;
         serial_valid <= 1'b0;
         serial_out   <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         done         <= done_n;
         serial_valid <= valid_n;
         if (shift_en) serial_out <= msb;
      end
   end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Self-checking bench for shift_reg_sequencer against a transaction-level reference model.
module tb_shift_reg_sequencer;
   import shift_reg_seq_pkg::*;

   localparam int WIDTH = 4;
   localparam int CW    = 3;

   logic             clk;
   logic             reset;
   logic             serial_in;
   logic             serial_out;
   logic             serial_valid;
   logic [WIDTH-1:0] dout;
   logic             busy;
   logic             done;

   int checks   = 0;
   int failures = 0;

   logic [WIDTH-1:0] model_reg;
   logic             last_out;

   shift_reg_sequencer_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

   shift_reg_sequencer #(.WIDTH(WIDTH), .CW(CW)) dut (
      .clk          (clk),
      .reset        (reset),
      .cmd          (bus),
      .serial_in    (serial_in),
      .serial_out   (serial_out),
      .serial_valid (serial_valid),
      .dout         (dout),
      .busy         (busy),
      .done         (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Register value after j shifts with the given LSB-fill bits, as integer arithmetic.
   function automatic logic [WIDTH-1:0] shifted(input logic [WIDTH-1:0] r,
                                                input logic [WIDTH-1:0] bits, input int j);
      int v;
      v = int'(r);
      for (int i = 0; i < j; i++) v = (v * 2 + int'(bits[i])) % (1 << WIDTH);
      return v[WIDTH-1:0];
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         bus.cmd_valid = 1'b0;
         serial_in     = 1'($urandom_range(0, 1));
         @(posedge clk);
         @(negedge clk);
         check("idle_done",  done,          0);
         check("idle_valid", serial_valid,  0);
         check("idle_ready", bus.cmd_ready, 1);
         check("idle_busy",  busy,          0);
         check("idle_dout",  dout,          model_reg);
         check("idle_hold",  serial_out,    last_out);
      end
   endtask

   // sin_fix < 0 draws random serial_in bits, otherwise uses the fixed value.
   task automatic issue(input op_t op, input logic [WIDTH-1:0] data,
                        input logic [CW-1:0] count, input int sin_fix);
      int n;
      logic [WIDTH-1:0] start;
      logic [WIDTH-1:0] sin;
      logic [WIDTH-1:0] exp_dout;
      int exp_bit;
      for (int i = 0; i < WIDTH; i++)
         sin[i] = (sin_fix < 0) ? 1'($urandom_range(0, 1)) : 1'(sin_fix);
      case (op)
         OP_LOAD:  begin start = data;      n = 0; end
         OP_CLEAR: begin start = '0;        n = 0; end
         OP_XFER:  begin start = data;      n = WIDTH; end
         default:  begin start = model_reg; n = (int'(count) > WIDTH) ? WIDTH : int'(count); end
      endcase
      check("accept_ready", bus.cmd_ready, 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_data  = data;
      bus.cmd_count = count;
      serial_in     = sin[0];
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.cmd_data  = WIDTH'($urandom);
      bus.cmd_count = CW'($urandom);
      if (n == 0) begin
         model_reg = start;
         check("cmd_done",  done,          1);
         check("cmd_valid", serial_valid,  0);
         check("cmd_dout",  dout,          model_reg);
         check("cmd_ready", bus.cmd_ready, 1);
         check("cmd_busy",  busy,          0);
         check("cmd_hold",  serial_out,    last_out);
      end else begin
         check("sh0_busy",  busy,          1);
         check("sh0_ready", bus.cmd_ready, 0);
         check("sh0_valid", serial_valid,  0);
         check("sh0_done",  done,          0);
         check("sh0_dout",  dout,          start);
         for (int j = 1; j <= n; j++) begin
            @(posedge clk);
            @(negedge clk);
            exp_dout = shifted(start, sin, j);
            exp_bit  = (int'(start) >> (WIDTH - j)) & 1;
            check("sh_valid", serial_valid,  1);
            check("sh_out",   serial_out,    32'(exp_bit));
            check("sh_dout",  dout,          exp_dout);
            check("sh_done",  done,          32'(j == n));
            check("sh_busy",  busy,          32'(j < n));
            check("sh_ready", bus.cmd_ready, 32'(j == n));
            last_out = 1'(exp_bit);
            if (j < n) serial_in = sin[j];
         end
         model_reg = shifted(start, sin, n);
      end
   endtask

   initial begin
      reset         = 1'b1;
      serial_in     = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_LOAD;
      bus.cmd_data  = '0;
      bus.cmd_count = '0;
      model_reg     = '0;
      last_out      = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst_dout",  dout,          0);
      check("rst_valid", serial_valid,  0);
      check("rst_done",  done,          0);
      check("rst_busy",  busy,          0);
      check("rst_ready", bus.cmd_ready, 1);

      issue(OP_LOAD, 4'b1010, '0, 0);
      check("load_dout", dout, 4'b1010);
      issue(OP_CLEAR, 4'b1111, '0, 0);
      check("clear_dout", dout, 4'b0000);
      idle(1);

      issue(OP_XFER, 4'b1101, '0, 0);
      check("xfer_final", dout, 4'b0000);
      idle(1);

      issue(OP_LOAD, 4'b1010, '0, 0);
      issue(OP_SHIFT, '0, 3'd2, 1);
      check("shift2_final", dout, 4'b1011);
      idle(1);

      issue(OP_SHIFT, '0, 3'd0, -1);
      idle(1);
      issue(OP_SHIFT, '0, 3'd7, -1);
      idle(1);

      // Reset lands on the second shift edge of an XFER.
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_XFER;
      bus.cmd_data  = 4'b1111;
      serial_in     = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort_valid1", serial_valid, 1);
      check("abort_out1",   serial_out,   1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reg = '0;
      last_out  = 1'b0;
      check("abort_ready", bus.cmd_ready, 1);
      check("abort_busy",  busy,          0);
      check("abort_dout",  dout,          0);
      check("abort_valid", serial_valid,  0);
      check("abort_done",  done,          0);
      idle(3);

      for (int k = 0; k < 60; k++) begin
         issue(op_t'($urandom_range(0, 3)), WIDTH'($urandom), CW'($urandom), -1);
         idle($urandom_range(0, 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
